// File: rtl/switchres_modeline_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : switchres_modeline_loader_if
// Purpose  : DDR read-port bundle between the modeline loader (master) and
//            the DDR arbiter (slave).
// Signals  : ddr_rd         master->slave  read request, held until accepted
//            ddr_addr[27:0] master->slave  64-bit word address
//            ddr_busy       slave->master  request accepted when ~ddr_busy
//            ddr_dout[63:0] slave->master  read data
//            ddr_dout_ready slave->master  ddr_dout valid this cycle
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface switchres_modeline_loader_if;
  logic        ddr_rd;
  logic [27:0] ddr_addr;
  logic        ddr_busy;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;

  modport master (
    output ddr_rd,
    output ddr_addr,
    input  ddr_busy,
    input  ddr_dout,
    input  ddr_dout_ready
  );

  modport slave (
    input  ddr_rd,
    input  ddr_addr,
    output ddr_busy,
    output ddr_dout,
    output ddr_dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/switchres_modeline_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : switchres_modeline_loader
// Purpose  : On a switchres command, fetch a 3-word modeline from DDR, check
//            it, and apply it to the timing outputs atomically at the next
//            rising edge of vblank; then acknowledge the command decoder.
// Ports    : clk_sys, reset_n          clock, async active-low reset
//            cmd_switchres             level request from command decoder
//            reset_switchres           one-cycle acknowledge pulse
//            ddr (master modport)      DDR read port
//            vga_vblank                vblank from timing generator
//            h_/v_active/begin/end/total, interlaced, pclk_div
//                                      applied video timings
//            timing_update             pulse on the cycle the timings change
//            busy                      high whenever not IDLE
//            error                     sticky: bad modeline or DDR timeout
// Options  : `define SWITCHRES_CHECK_EN enables modeline sanity checking;
//            without it every fetched modeline is applied.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module switchres_modeline_loader #(
  parameter logic [27:0] MODELINE_ADDR  = 28'h0010000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  wire logic                   clk_sys,
  input  wire logic                   reset_n,
  input  wire logic                   cmd_switchres,
  output logic                        reset_switchres,
  switchres_modeline_loader_if.master ddr,
  input  wire logic                   vga_vblank,
  output logic [15:0]                 h_active,
  output logic [15:0]                 h_begin,
  output logic [15:0]                 h_end,
  output logic [15:0]                 h_total,
  output logic [15:0]                 v_active,
  output logic [15:0]                 v_begin,
  output logic [15:0]                 v_end,
  output logic [15:0]                 v_total,
  output logic                        interlaced,
  output logic [7:0]                  pclk_div,
  output logic                        timing_update,
  output logic                        busy,
  output logic                        error
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_REQ   = 4'd1;
  localparam logic [3:0] S_WAIT  = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_PEND  = 4'd4;
  localparam logic [3:0] S_APPLY = 4'd5;
  localparam logic [3:0] S_ABORT = 4'd6;
  localparam logic [3:0] S_ACK   = 4'd7;
  localparam logic [3:0] S_GAP   = 4'd8;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   shadow0_q, shadow0_d;
  logic [63:0]   shadow1_q, shadow1_d;
  logic [8:0]    shadow2_q, shadow2_d;
  logic          vblank_q, vblank_d;
  logic          error_q, error_d;
  logic [63:0]   h_q, h_d;
  logic [63:0]   v_q, v_d;
  logic [8:0]    misc_q, misc_d;

  logic          tmo_hit;
  logic          vblank_rise;
  logic          apply_go;
  logic          modeline_ok;

  // Last cycle of the per-word budget: REQ+WAIT may last TIMEOUT_CYCLES.
  assign tmo_hit     = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));
  // vblank_q tracks vblank in every state, so a vblank already high when PEND
  // is entered never looks like an edge.
  assign vblank_rise = vga_vblank & ~vblank_q;
  assign apply_go    = (state_q == S_PEND) & vblank_rise;

`ifdef SWITCHRES_CHECK_EN
  function automatic logic order_ok(input logic [63:0] w);
    return (w[63:48] != 16'd0) &&
           (w[63:48] <  w[47:32]) &&
           (w[47:32] <  w[31:16]) &&
           (w[31:16] <= w[15:0]);
  endfunction

  assign modeline_ok = order_ok(shadow0_q) && order_ok(shadow1_q) &&
                       (shadow2_q[7:0] != 8'd0);
`else
  assign modeline_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_switchres) state_d = S_REQ;
      S_REQ: begin
        if (tmo_hit)            state_d = S_ABORT;
        else if (!ddr.ddr_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving on the final budget cycle still counts.
        if (ddr.ddr_dout_ready) state_d = (idx_q == 2'd2) ? S_CHECK : S_REQ;
        else if (tmo_hit)       state_d = S_ABORT;
      end
      S_CHECK: state_d = modeline_ok ? S_PEND : S_ABORT;
      S_PEND:  if (vblank_rise) state_d = S_APPLY;
      S_APPLY: state_d = S_ACK;
      S_ABORT: state_d = S_ACK;
      S_ACK:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ddr.ddr_rd      = 1'b0;
    ddr.ddr_addr    = 28'd0;
    timing_update   = 1'b0;
    reset_switchres = 1'b0;
    busy            = (state_q != S_IDLE);
    case (state_q)
      S_REQ: begin
        ddr.ddr_rd   = 1'b1;
        ddr.ddr_addr = MODELINE_ADDR + 28'(idx_q);
      end
      S_APPLY: timing_update   = 1'b1;
      S_ACK:   reset_switchres = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    vblank_d  = vga_vblank;
    error_d   = error_q;
    h_d       = h_q;
    v_d       = v_q;
    misc_d    = misc_q;

    if (state_q == S_IDLE) begin
      idx_d = 2'd0;
    end else if ((state_q == S_WAIT) && ddr.ddr_dout_ready && (idx_q != 2'd2)) begin
      idx_d = 2'(idx_q + 2'd1);
    end

    // Budget restarts for every word fetched.
    if ((state_d == S_REQ) && (state_q != S_REQ)) begin
      tmo_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      tmo_d = TW'(tmo_q + 1'b1);
    end

    if ((state_q == S_WAIT) && ddr.ddr_dout_ready) begin
      case (idx_q)
        2'd0:    shadow0_d = ddr.ddr_dout;
        2'd1:    shadow1_d = ddr.ddr_dout;
        default: shadow2_d = ddr.ddr_dout[8:0];
      endcase
    end

    // Outputs load on the edge into APPLY, so the new timings are visible in
    // the same cycle that timing_update is high.
    if (apply_go) begin
      h_d     = shadow0_q;
      v_d     = shadow1_q;
      misc_d  = shadow2_q;
      error_d = 1'b0;
    end else if (state_q == S_ABORT) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= 2'd0;
      tmo_q     <= '0;
      shadow0_q <= 64'd0;
      shadow1_q <= 64'd0;
      shadow2_q <= 9'd0;
      vblank_q  <= 1'b0;
      error_q   <= 1'b0;
      h_q       <= 64'd0;
      v_q       <= 64'd0;
      misc_q    <= 9'd0;
    end else begin
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      shadow2_q <= shadow2_d;
      vblank_q  <= vblank_d;
      error_q   <= error_d;
      h_q       <= h_d;
      v_q       <= v_d;
      misc_q    <= misc_d;
    end
  end

  assign h_active   = h_q[63:48];
  assign h_begin    = h_q[47:32];
  assign h_end      = h_q[31:16];
  assign h_total    = h_q[15:0];
  assign v_active   = v_q[63:48];
  assign v_begin    = v_q[47:32];
  assign v_end      = v_q[31:16];
  assign v_total    = v_q[15:0];
  assign interlaced = misc_q[8];
  assign pclk_div   = misc_q[7:0];
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_switchres_modeline_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_switchres_modeline_loader
// Purpose  : Self-checking bench for switchres_modeline_loader. A table of
//            modelines is loaded through a behavioural DDR model, followed by
//            directed sequences for vblank-already-high, DDR back-pressure,
//            read timeout and reset during a fetch.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_switchres_modeline_loader;

  localparam logic [27:0] MA = 28'h0010000;
`ifdef SWITCHRES_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n;
  logic cmd_switchres;
  logic reset_switchres;
  logic vga_vblank;
  logic [15:0] h_active, h_begin, h_end, h_total;
  logic [15:0] v_active, v_begin, v_end, v_total;
  logic interlaced;
  logic [7:0] pclk_div;
  logic timing_update, busy, error;

  switchres_modeline_loader_if ddr_if ();

  switchres_modeline_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .cmd_switchres  (cmd_switchres),
    .reset_switchres(reset_switchres),
    .ddr            (ddr_if),
    .vga_vblank     (vga_vblank),
    .h_active       (h_active),
    .h_begin        (h_begin),
    .h_end          (h_end),
    .h_total        (h_total),
    .v_active       (v_active),
    .v_begin        (v_begin),
    .v_end          (v_end),
    .v_total        (v_total),
    .interlaced     (interlaced),
    .pclk_div       (pclk_div),
    .timing_update  (timing_update),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk_sys = ~clk_sys;

  logic [136:0] out_vec;
  assign out_vec = {h_active, h_begin, h_end, h_total,
                    v_active, v_begin, v_end, v_total, interlaced, pclk_div};

  // ---------------- DDR model ----------------
  logic [63:0] mem_w0, mem_w1, mem_w2;
  int          busy_hold  = 0;
  bit          respond_en = 1'b1;
  int          rd_held_cnt = 0;
  logic [27:0] addr_log[$];

  initial begin
    int          busy_left;
    int          lat_cnt;
    bit          in_req;
    logic [27:0] pend_addr;
    busy_left = 0; lat_cnt = 0; in_req = 1'b0; pend_addr = '0;
    ddr_if.ddr_busy       = 1'b0;
    ddr_if.ddr_dout       = 64'd0;
    ddr_if.ddr_dout_ready = 1'b0;
    forever begin
      @(negedge clk_sys);
      ddr_if.ddr_dout_ready = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && respond_en) begin
          case (pend_addr - MA)
            28'd0:   ddr_if.ddr_dout = mem_w0;
            28'd1:   ddr_if.ddr_dout = mem_w1;
            28'd2:   ddr_if.ddr_dout = mem_w2;
            default: ddr_if.ddr_dout = 64'hDEAD_BEEF_DEAD_BEEF;
          endcase
          ddr_if.ddr_dout_ready = 1'b1;
        end
      end
      if (ddr_if.ddr_rd) begin
        if (!in_req) begin
          in_req    = 1'b1;
          busy_left = busy_hold;
        end
        if (busy_left > 0) begin
          ddr_if.ddr_busy = 1'b1;
          busy_left--;
          rd_held_cnt++;
        end else begin
          ddr_if.ddr_busy = 1'b0;
          addr_log.push_back(ddr_if.ddr_addr);
          pend_addr = ddr_if.ddr_addr;
          lat_cnt   = 3;
          in_req    = 1'b0;
        end
      end else begin
        ddr_if.ddr_busy = 1'b0;
        in_req          = 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_err    = 0;
  int n_checks = 0;
  int tu_cnt   = 0;
  int ack_cnt  = 0;

  logic [136:0] exp_out = '0;
  logic         exp_err = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; acts as the command decoder and counts pulses.
  task automatic step();
    @(negedge clk_sys);
    if (timing_update) tu_cnt++;
    if (reset_switchres) begin
      ack_cnt++;
      cmd_switchres = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w2;
    bit          valid;   // passes sanity checking
    int          dly;     // cycles from cmd to vblank edge
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    bit apply;
    bit ok;
    apply   = !CHK || v.valid;
    tu_cnt  = 0;
    ack_cnt = 0;
    mem_w0  = v.w0;
    mem_w1  = v.w1;
    mem_w2  = v.w2;
    cmd_switchres = 1'b1;
    repeat (v.dly) step();
    vga_vblank = 1'b1;
    step();
    if (apply) begin
      exp_out = {v.w0, v.w1, v.w2[8:0]};
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    chk({v.name, ":tu_at_edge"}, 256'(timing_update), 256'(apply));
    chk({v.name, ":out_at_edge"}, 256'(out_vec), 256'(exp_out));
    wait_idle(ok);
    chk({v.name, ":done"}, 256'(ok), 256'(1));
    chk({v.name, ":tu_cnt"}, 256'(tu_cnt), 256'(apply ? 1 : 0));
    chk({v.name, ":ack_cnt"}, 256'(ack_cnt), 256'(1));
    chk({v.name, ":error"}, 256'(error), 256'(exp_err));
    chk({v.name, ":out_final"}, 256'(out_vec), 256'(exp_out));
    vga_vblank = 1'b0;
    step();
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int n;
    int base;
    int held0;
    vec_t v;

    vecs[0] = '{"vga",     {16'd640, 16'd656, 16'd752, 16'd800},  {16'd480, 16'd490, 16'd492, 16'd525}, 64'h004, 1'b1, 500};
    vecs[1] = '{"svga_il", {16'd800, 16'd840, 16'd968, 16'd1056}, {16'd600, 16'd601, 16'd605, 16'd628}, 64'h102, 1'b1, 40};
    vecs[2] = '{"hbeg_lt", {16'd640, 16'd600, 16'd752, 16'd800},  {16'd480, 16'd490, 16'd492, 16'd525}, 64'h004, 1'b0, 40};
    vecs[3] = '{"zeros",   64'd0, 64'd0, 64'd0, 1'b0, 40};
    vecs[4] = '{"hend_eq", {16'd320, 16'd336, 16'd368, 16'd368},  {16'd240, 16'd244, 16'd247, 16'd262}, 64'h108, 1'b1, 40};
    vecs[5] = '{"div0",    {16'd640, 16'd656, 16'd752, 16'd800},  {16'd480, 16'd490, 16'd492, 16'd525}, 64'h000, 1'b0, 40};
    vecs[6] = '{"vbeg_eq", {16'd640, 16'd656, 16'd752, 16'd800},  {16'd480, 16'd480, 16'd492, 16'd525}, 64'h004, 1'b0, 40};
    vecs[7] = '{"xga",     {16'd1024, 16'd1048, 16'd1184, 16'd1344}, {16'd768, 16'd771, 16'd777, 16'd777}, 64'h003, 1'b1, 40};

    reset_n       = 1'b1;
    cmd_switchres = 1'b0;
    vga_vblank    = 1'b0;
    mem_w0 = '0; mem_w1 = '0; mem_w2 = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst:outputs", 256'(out_vec), 256'(0));
    chk("rst:flags", 256'({busy, error, timing_update, reset_switchres, ddr_if.ddr_rd}), 256'(0));
    chk("rst:addr", 256'(ddr_if.ddr_addr), 256'(0));
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // vblank already high when PEND is entered: the first edge must be a
    // fresh one after vblank has dropped.
    tu_cnt = 0; ack_cnt = 0;
    mem_w0 = vecs[1].w0; mem_w1 = vecs[1].w1; mem_w2 = vecs[1].w2;
    vga_vblank    = 1'b1;
    cmd_switchres = 1'b1;
    repeat (40) step();
    chk("vbhi:pending", 256'(busy), 256'(1));
    chk("vbhi:no_apply", 256'(tu_cnt), 256'(0));
    vga_vblank = 1'b0;
    repeat (3) step();
    chk("vbhi:no_apply_low", 256'(tu_cnt), 256'(0));
    vga_vblank = 1'b1;
    step();
    exp_out = {vecs[1].w0, vecs[1].w1, vecs[1].w2[8:0]};
    exp_err = 1'b0;
    chk("vbhi:tu_at_edge", 256'(timing_update), 256'(1));
    chk("vbhi:out", 256'(out_vec), 256'(exp_out));
    wait_idle(ok);
    chk("vbhi:done", 256'(ok), 256'(1));
    chk("vbhi:ack_cnt", 256'(ack_cnt), 256'(1));
    vga_vblank = 1'b0;
    repeat (2) step();

    // DDR back-pressure: each request held busy for 10 cycles.
    busy_hold = 10;
    base  = addr_log.size();
    held0 = rd_held_cnt;
    v = vecs[4];
    v.dly = 80;
    run_vec(v);
    chk("bp:n_reads", 256'(addr_log.size() - base), 256'(3));
    if (addr_log.size() >= base + 3) begin
      for (int i = 0; i < 3; i++)
        chk("bp:addr", 256'(addr_log[base + i]), 256'(MA + 28'(i)));
    end
    chk("bp:rd_held", 256'(rd_held_cnt - held0), 256'(30));
    busy_hold = 0;

    // Read timeout: DDR accepts but never returns data.
    respond_en = 1'b0;
    tu_cnt = 0; ack_cnt = 0;
    cmd_switchres = 1'b1;
    n = 0;
    while (ack_cnt == 0 && n < 5000) begin
      step();
      n++;
    end
    chk("to:ack", 256'(ack_cnt), 256'(1));
    chk("to:latency_ok", 256'(n >= 4096 && n <= 4110), 256'(1));
    chk("to:error", 256'(error), 256'(1));
    chk("to:out_kept", 256'(out_vec), 256'(exp_out));
    chk("to:tu_cnt", 256'(tu_cnt), 256'(0));
    repeat (3) step();
    chk("to:idle", 256'(busy), 256'(0));
    respond_en = 1'b1;

    // Reset asserted while waiting for DDR data.
    tu_cnt = 0; ack_cnt = 0;
    mem_w0 = vecs[0].w0; mem_w1 = vecs[0].w1; mem_w2 = vecs[0].w2;
    cmd_switchres = 1'b1;
    step();
    step();
    chk("rw:in_wait", 256'({busy, ddr_if.ddr_rd}), 256'(2'b10));
    reset_n       = 1'b0;
    cmd_switchres = 1'b0;
    #1;
    chk("rw:outputs", 256'(out_vec), 256'(0));
    chk("rw:flags", 256'({busy, error, timing_update, reset_switchres, ddr_if.ddr_rd}), 256'(0));
    repeat (4) step();
    chk("rw:no_ack", 256'(ack_cnt), 256'(0));
    reset_n = 1'b1;
    exp_out = '0;
    exp_err = 1'b0;
    repeat (2) step();
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
